// File: rtl/gradient_pkg.sv
// rtl/gradient_pkg.sv - shared constants, Sobel kernels and FSM state type for gradient_matrix_mult
//   ELEM_W/N/ACC_W/MAT_W : element width, matrix order, signed accumulator width, packed matrix width
//   KX/KY                : fixed Sobel coefficient matrices
//   state_t              : engine FSM states
package gradient_pkg;

    localparam int ELEM_W = 24;
    localparam int N      = 3;
    localparam int ACC_W  = 27;
    localparam int MAT_W  = ELEM_W * N * N;

    localparam logic [ELEM_W-1:0] SAT_MAX = {ELEM_W{1'b1}};

    localparam logic signed [2:0] KX [N][N] = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd2, 3'sd0, 3'sd2},
        '{-3'sd1, 3'sd0, 3'sd1}
    };

    localparam logic signed [2:0] KY [N][N] = '{
        '{-3'sd1, -3'sd2, -3'sd1},
        '{ 3'sd0,  3'sd0,  3'sd0},
        '{ 3'sd1,  3'sd2,  3'sd1}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gm_element.sv
// rtl/gm_element.sv - combinational |Gx|+|Gy| for one output element, saturated to ELEM_W
//   col_i : column j of the latched window, row k at col_i[k*ELEM_W +: ELEM_W]
//   row_i : output row index i (values above N-1 behave as row 0)
//   gm_o  : saturated gradient magnitude for element (i,j)
module gm_element
    import gradient_pkg::*;
(
    input  logic [N*ELEM_W-1:0] col_i,
    input  logic [1:0]          row_i,
    output logic [ELEM_W-1:0]   gm_o
);

    logic        [1:0]       row_sel;
    logic signed [ACC_W-1:0] elem;
    logic signed [ACC_W-1:0] kx_ext;
    logic signed [ACC_W-1:0] ky_ext;
    logic signed [ACC_W-1:0] gx;
    logic signed [ACC_W-1:0] gy;
    logic        [ACC_W-1:0] abs_gx;
    logic        [ACC_W-1:0] abs_gy;
    // One extra bit so the magnitude sum can never wrap before saturation.
    logic        [ACC_W:0]   mag;

    always_comb begin
        row_sel = (row_i > 2'd2) ? 2'd0 : row_i;
        gx      = '0;
        gy      = '0;
        elem    = '0;
        kx_ext  = '0;
        ky_ext  = '0;
        for (int k = 0; k < N; k++) begin
            elem   = $signed({{(ACC_W-ELEM_W){1'b0}}, col_i[k*ELEM_W +: ELEM_W]});
            kx_ext = $signed({{(ACC_W-3){KX[row_sel][k][2]}}, KX[row_sel][k]});
            ky_ext = $signed({{(ACC_W-3){KY[row_sel][k][2]}}, KY[row_sel][k]});
            gx     = gx + kx_ext * elem;
            gy     = gy + ky_ext * elem;
        end
        abs_gx = gx[ACC_W-1] ? ACC_W'(-gx) : ACC_W'(gx);
        abs_gy = gy[ACC_W-1] ? ACC_W'(-gy) : ACC_W'(gy);
        mag    = {1'b0, abs_gx} + {1'b0, abs_gy};
        if (mag > {{(ACC_W+1-ELEM_W){1'b0}}, SAT_MAX}) begin
            gm_o = SAT_MAX;
        end else begin
            gm_o = mag[ELEM_W-1:0];
        end
    end

endmodule

// File: rtl/gradient_matrix_mult.sv
// rtl/gradient_matrix_mult.sv - sequential 3x3 Sobel gradient-magnitude engine, one element per cycle
//   Clock  : rising-edge clock
//   reset  : asynchronous active-high, clears all state
//   Enable : level start/hold request
//   A      : input window, element (i,j) at A[(i*3+j)*24 +: 24]
//   GM     : gradient magnitude matrix, same packing as A
//   done   : high while the result is held in DONE
module gradient_matrix_mult
    import gradient_pkg::*;
(
    input  logic             Clock,
    input  logic             reset,
    input  logic             Enable,
    input  logic [MAT_W-1:0] A,
    output logic [MAT_W-1:0] GM,
    output logic             done
);

    localparam logic [3:0] LAST_IDX  = 4'd8;
    localparam logic [3:0] DRAIN_IDX = 4'd9;

    state_t             state_q;
    logic [3:0]         idx_q;
    logic [MAT_W-1:0]   a_q;
    logic [MAT_W-1:0]   gm_q;
    logic               done_q;

    logic [1:0]         row_idx;
    logic [1:0]         col_idx;
    logic [N*ELEM_W-1:0] col_d;
    logic [ELEM_W-1:0]  elem_d;

    assign row_idx = 2'(idx_q / 4'd3);
    assign col_idx = 2'(idx_q % 4'd3);

    always_comb begin
        col_d = '0;
        for (int k = 0; k < N; k++) begin
            col_d[k*ELEM_W +: ELEM_W] = a_q[(k*N + int'(col_idx))*ELEM_W +: ELEM_W];
        end
    end

    gm_element u_gm_element (
        .col_i (col_d),
        .row_i (row_idx),
        .gm_o  (elem_d)
    );

    // idx runs 0..8 writing GM, then one drain step at idx 9 so done is
    // registered on the edge after the final element write.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            gm_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Enable) begin
                        a_q     <= A;
                        idx_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (idx_q <= LAST_IDX) begin
                        gm_q[int'(idx_q)*ELEM_W +: ELEM_W] <= elem_d;
                        idx_q <= idx_q + 4'd1;
                    end
                    if (idx_q == DRAIN_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!Enable) begin
                        done_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign GM   = gm_q;
    assign done = done_q;

endmodule

// File: tb/tb_gradient_matrix_mult.sv
// tb/tb_gradient_matrix_mult.sv - directed self-checking bench for gradient_matrix_mult
module tb_gradient_matrix_mult;

    logic         Clock;
    logic         reset;
    logic         Enable;
    logic [215:0] A;
    logic [215:0] GM;
    logic         done;

    int total;
    int bad;

    gradient_matrix_mult dut (
        .Clock  (Clock),
        .reset  (reset),
        .Enable (Enable),
        .A      (A),
        .GM     (GM),
        .done   (done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [215:0] pack9(input int e0, input int e1, input int e2,
                                           input int e3, input int e4, input int e5,
                                           input int e6, input int e7, input int e8);
        logic [215:0] m;
        m = '0;
        m[0*24 +: 24] = 24'(e0); m[1*24 +: 24] = 24'(e1); m[2*24 +: 24] = 24'(e2);
        m[3*24 +: 24] = 24'(e3); m[4*24 +: 24] = 24'(e4); m[5*24 +: 24] = 24'(e5);
        m[6*24 +: 24] = 24'(e6); m[7*24 +: 24] = 24'(e7); m[8*24 +: 24] = 24'(e8);
        return m;
    endfunction

    // Starts a run at the next negedge, then reports after which edge done
    // was first seen high (edge 0 is the latch edge); -1 if never seen.
    task automatic start_and_wait(input logic [215:0] a, input logic scramble_a,
                                  input int drop_after, output int lat);
        lat = -1;
        @(negedge Clock);
        A = a;
        Enable = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (scramble_a && e == 0) A = {7{$urandom()}};
            if (drop_after >= 0 && e == drop_after) Enable = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        Enable = 1'b0;
        A      = '0;
        #100;
        total++;
        if (GM !== '0) begin
            bad++;
            $display("FAIL reset_gm: got %h expected 0", GM);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        @(negedge Clock);
        reset = 1'b0;
    endtask

    task automatic run_vector(input string name, input logic [215:0] a,
                              input logic [215:0] expv, input logic scramble_a);
        int lat;
        start_and_wait(a, scramble_a, -1, lat);
        total++;
        if (lat != 10) begin
            bad++;
            $display("FAIL %s_latency: got %0d expected 10", name, lat);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (GM[i*24 +: 24] !== expv[i*24 +: 24]) begin
                bad++;
                $display("FAIL %s_gm[%0d]: got %0d expected %0d", name, i,
                         GM[i*24 +: 24], expv[i*24 +: 24]);
            end
        end
        // Holding Enable keeps DONE.
        @(posedge Clock);
        @(negedge Clock);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_hold_done: got %b expected 1", name, done);
        end
        Enable = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_fall: got %b expected 0", name, done);
        end
        total++;
        if (GM !== expv) begin
            bad++;
            $display("FAIL %s_gm_hold: got %h expected %h", name, GM, expv);
        end
    endtask

    task automatic test_vec1();
        run_vector("vec1", pack9(0, 2, 253, 153, 3, 154, 253, 0, 0),
                   pack9(812, 10, 814, 506, 4, 506, 812, 10, 814), 1'b1);
    endtask

    task automatic test_vec2();
        run_vector("vec2", pack9(255, 255, 255, 177, 254, 255, 255, 255, 255),
                   pack9(864, 1018, 1020, 0, 0, 0, 864, 1018, 1020), 1'b0);
    endtask

    task automatic test_zero();
        run_vector("zero", '0, '0, 1'b0);
    endtask

    task automatic test_saturate();
        run_vector("sat", pack9(0, 0, 0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0),
                   pack9(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0,
                         24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF), 1'b0);
    endtask

    task automatic test_reset_mid_calc();
        @(negedge Clock);
        A = pack9(0, 2, 253, 153, 3, 154, 253, 0, 0);
        Enable = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            @(posedge Clock);
        end
        @(negedge Clock);
        reset = 1'b1;
        #1;
        total++;
        if (GM !== '0) begin
            bad++;
            $display("FAIL midreset_gm: got %h expected 0", GM);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_done: got %b expected 0", done);
        end
        Enable = 1'b0;
        @(negedge Clock);
        reset = 1'b0;
        run_vector("restart", pack9(255, 255, 255, 177, 254, 255, 255, 255, 255),
                   pack9(864, 1018, 1020, 0, 0, 0, 864, 1018, 1020), 1'b0);
    endtask

    task automatic test_enable_drop();
        int lat;
        start_and_wait(pack9(0, 2, 253, 153, 3, 154, 253, 0, 0), 1'b0, 3, lat);
        total++;
        if (lat != 10) begin
            bad++;
            $display("FAIL drop_latency: got %0d expected 10", lat);
        end
        total++;
        if (GM !== pack9(812, 10, 814, 506, 4, 506, 812, 10, 814)) begin
            bad++;
            $display("FAIL drop_gm: got %h", GM);
        end
        @(posedge Clock);
        @(negedge Clock);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL drop_done_fall: got %b expected 0", done);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        test_reset();
        test_vec1();
        test_vec2();
        test_zero();
        test_saturate();
        test_reset_mid_calc();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gradient_matrix_mult.md
# gradient_matrix_mult

Sequential 3×3 Sobel gradient-magnitude engine for the edge-detection datapath. It latches a 3×3 window of 24-bit pixels and forms the matrix products Gx = Kx·A and Gy = Ky·A, one element per cycle. It outputs GM[i][j] = |Gx[i][j]| + |Gy[i][j]| as a packed 3×3 matrix and raises `done`. It feeds the downstream double-thresholding stage.

## Interface
- No parameters. Element width is 24 and matrix size is 3×3; both are fixed constants.
- Clock: one clock, named `Clock`. Reset is asynchronous and active-high, named `reset`.
- `Clock  in  1`  rising-edge clock.
- `reset  in  1`  asynchronous, active-high; clears all state.
- `Enable  in  1`  start/hold request, level-sensitive.
- `A  in  216`  input matrix; element (i,j) (row i, col j) is `A[(i*3+j)*24 +: 24]`, unsigned.
- `GM  out  216`  gradient magnitude matrix, same packing as `A`, unsigned.
- `done  out  1`  result valid; high while in DONE.

## Operation
- Kernels are fixed:
  - Kx = [[-1,0,1],[-2,0,2],[-1,0,1]].
  - Ky = [[-1,-2,-1],[0,0,0],[1,2,1]].
- Gx[i][j] = Σk Kx[i][k]·A[k][j], which reduces to c_i·(A[2][j]−A[0][j]) with c = {1,2,1}.
- Gy[i][j] = Σk Ky[i][k]·A[k][j]. Row 0 is −s_j, row 1 is 0, row 2 is +s_j, where s_j = A[0][j]+2A[1][j]+A[2][j].
- Arithmetic uses signed, at least 27 bits. GM = |Gx|+|Gy|, saturated to 24'hFFFFFF if it exceeds 24 bits.
- FSM states: IDLE, CALC, DONE.
  - IDLE: when `Enable`=1, latch `A` into an internal register, set idx=0, go to CALC.
  - CALC: each cycle, write element idx (row-major, idx = i*3+j) into the GM register and increment idx. After idx=8, go to DONE.
  - DONE: `done`=1. Stay while `Enable`=1. When `Enable`=0, go to IDLE with `done`=0.
- `GM` holds its last value until reset or until overwritten by a new run.
- Changes on `A` after the latch cycle are ignored until the next run.
- `Enable` dropping during CALC does not abort the run; it completes to DONE, then returns to IDLE in the next cycle.

## Timing
- Reset (asynchronous, any state, including mid-CALC): state=IDLE, idx=0, `GM`=0, `done`=0, latched A=0.
- Edge 0 is the rising edge where IDLE samples `Enable`=1; A is latched on that edge.
- Edges 1..9 write GM elements 0..8.
- `done` rises on edge 10, a latency of 10 cycles. All 9 GM elements are valid and stable when `done` is high.
- `done` falls on the first edge that samples `Enable`=0 in DONE.
- A new run requires `Enable` low for at least one edge, or a reset, between runs.

## Structure
- Shared package `gradient_pkg` holds:
  - `ELEM_W`=24, `N`=3, `ACC_W`=27.
  - The Kx/Ky coefficient constants.
  - State enum {IDLE, CALC, DONE}.
- One combinational sub-module, `gm_element`. Inputs: column j of the latched A (3×24) and row index i. Output: 24-bit saturated |Gx|+|Gy|.
- The top module holds the FSM, the index counter, the A latch and the GM register.

## Test plan
- Reset for 100 time units with `Enable`=0 -> `GM`=0, `done`=0.
- A rows [0,2,253],[153,3,154],[253,0,0], `Enable`=1 -> `done` after 10 cycles; GM rows [812,10,814],[506,4,506],[812,10,814].
- A rows [255,255,255],[177,254,255],[255,255,255] -> GM rows [864,1018,1020],[0,0,0],[864,1018,1020].
- All-zero A -> GM all 0, `done` asserted at cycle 10.
- All elements 24'hFFFFFF in row 1, 0 elsewhere -> |Gy| saturates; GM rows 0 and 2 = 24'hFFFFFF, row 1 = 0.
- Assert `reset` mid-CALC (cycle 5) -> `GM`=0 and `done`=0 immediately. The next `Enable` restarts from idx 0 and `done` arrives 10 cycles later.
